// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline hazard and sequencing controller for the five-stage core.
//   Detects load-use and MDU-busy hazards in ID, squashes the wrong path on
//   a taken branch in EX, tracks the multi-cycle multiply/divide unit with a
//   countdown, and keeps saturating stall/flush statistics.
//
// Parameters
//   MDU_LATENCY      cycles the MDU stays busy after an accepted start (1..31)
//
// Ports
//   clk, rst_n       core clock, asynchronous active-low reset
//   IDRs, IDRt       source register fields of the ID instruction
//   IDUsesRs/Rt      ID instruction actually reads rs / rt
//   IDMduStart       ID instruction is mult/multu/div/divu
//   IDReadsHiLo      ID instruction is mfhi/mflo/mthi/mtlo
//   EXMemRead        EX instruction is a load
//   EXWriteRegAddr   destination register of the EX instruction
//   BranchTakenEX    branch/jump in EX resolved taken
//   ClearStats       synchronous clear of both statistics counters
//   PCWriteEnable    PC load enable
//   IFIDWriteEnable  IF/ID write enable
//   IFIDFlush        IF/ID flush
//   IDEXFlush        ID/EX flush (bubble into EX)
//   MduBusy          MDU countdown is nonzero
//   StallCycles      saturating count of stalled cycles
//   FlushEvents      saturating count of taken-branch squashes
module hazard_control #(
  parameter int unsigned MDU_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRs,
  input  logic        IDUsesRt,
  input  logic        IDMduStart,
  input  logic        IDReadsHiLo,
  input  logic        EXMemRead,
  input  logic [4:0]  EXWriteRegAddr,
  input  logic        BranchTakenEX,
  input  logic        ClearStats,
  output logic        PCWriteEnable,
  output logic        IFIDWriteEnable,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        MduBusy,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushEvents
);

  typedef enum logic [1:0] {
    CTRL_RESET,
    CTRL_SQUASH,
    CTRL_STALL,
    CTRL_RUN
  } ctrlMode_t;

  localparam logic [4:0] MduLoad = 5'(MDU_LATENCY);

  ctrlMode_t  mode;
  logic [4:0] mduCount;
  logic       loadUse;
  logic       mduHazard;
  logic       stall;
  logic       mduAccept;

  // Writes to $0 never create a dependency.
  always_comb begin
    loadUse = EXMemRead && (EXWriteRegAddr != '0) &&
              ((IDUsesRs && (EXWriteRegAddr == IDRs)) ||
               (IDUsesRt && (EXWriteRegAddr == IDRt)));
  end

  assign MduBusy   = (mduCount != '0);
  assign mduHazard = MduBusy && (IDMduStart || IDReadsHiLo);

  // A taken branch discards the ID instruction, so its hazards are moot.
  assign stall     = (loadUse || mduHazard) && !BranchTakenEX;

  // A squashed or stalled start must not launch the MDU.
  assign mduAccept = IDMduStart && !BranchTakenEX && !stall;

  // Reset is folded into the combinational mode so the pipeline is held
  // and flushed for as long as rst_n is low, not just at the edge.
  always_comb begin
    mode = CTRL_RUN;
    if (!rst_n)
      mode = CTRL_RESET;
    else if (BranchTakenEX)
      mode = CTRL_SQUASH;
    else if (stall)
      mode = CTRL_STALL;
  end

  always_comb begin
    PCWriteEnable   = 1'b1;
    IFIDWriteEnable = 1'b1;
    IFIDFlush       = 1'b0;
    IDEXFlush       = 1'b0;
    unique case (mode)
      CTRL_RESET: begin
        PCWriteEnable   = 1'b0;
        IFIDWriteEnable = 1'b0;
        IFIDFlush       = 1'b1;
        IDEXFlush       = 1'b1;
      end
      CTRL_SQUASH: begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end
      CTRL_STALL: begin
        PCWriteEnable   = 1'b0;
        IFIDWriteEnable = 1'b0;
        IDEXFlush       = 1'b1;
      end
      CTRL_RUN: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mduCount <= '0;
    else if (mduAccept)
      mduCount <= MduLoad;
    else if (mduCount != '0)
      mduCount <= mduCount - 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      StallCycles <= '0;
    else if (ClearStats)
      StallCycles <= '0;
    else if (stall && (StallCycles != '1))
      StallCycles <= StallCycles + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      FlushEvents <= '0;
    else if (ClearStats)
      FlushEvents <= '0;
    else if (BranchTakenEX && (FlushEvents != '1))
      FlushEvents <= FlushEvents + 16'd1;
  end

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IDRs, IDRt, EXWriteRegAddr;
  logic        IDUsesRs, IDUsesRt, IDMduStart, IDReadsHiLo;
  logic        EXMemRead, BranchTakenEX, ClearStats;
  logic        PCWriteEnable, IFIDWriteEnable, IFIDFlush, IDEXFlush, MduBusy;
  logic [15:0] StallCycles, FlushEvents;

  hazard_control #(.MDU_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDMduStart(IDMduStart), .IDReadsHiLo(IDReadsHiLo),
    .EXMemRead(EXMemRead), .EXWriteRegAddr(EXWriteRegAddr),
    .BranchTakenEX(BranchTakenEX), .ClearStats(ClearStats),
    .PCWriteEnable(PCWriteEnable), .IFIDWriteEnable(IFIDWriteEnable),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MduBusy(MduBusy),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  always #5 clk = ~clk;

  // {PCWriteEnable, IFIDWriteEnable, IFIDFlush, IDEXFlush, MduBusy}
  localparam logic [4:0] RUN    = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00010;
  localparam logic [4:0] SQUASH = 5'b11110;
  localparam logic [4:0] RST    = 5'b00110;
  localparam logic [4:0] BUSY   = 5'b00001;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
  } exp_t;

  exp_t        expQ[$];
  exp_t        e;
  logic [4:0]  ctl;
  int          nTests = 0;
  int          nFail  = 0;
  logic [15:0] expStall = '0;
  logic [15:0] expFlush = '0;

  assign ctl = {PCWriteEnable, IFIDWriteEnable, IFIDFlush, IDEXFlush, MduBusy};

  task automatic clearInputs();
    IDRs = '0; IDRt = '0; IDUsesRs = 0; IDUsesRt = 0;
    IDMduStart = 0; IDReadsHiLo = 0; EXMemRead = 0; EXWriteRegAddr = '0;
    BranchTakenEX = 0; ClearStats = 0;
  endtask

  // One clock edge; the expected statistics follow the cycle just completed.
  task automatic advance(input bit stalled, input bit flushed, input bit clr);
    @(posedge clk);
    #1;
    if (clr) begin
      expStall = '0;
      expFlush = '0;
    end else begin
      if (stalled && expStall != 16'hFFFF) expStall = expStall + 16'd1;
      if (flushed && expFlush != 16'hFFFF) expFlush = expFlush + 16'd1;
    end
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    expQ.push_back('{"reset_ctl", RST});
    #3;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    nTests++;
    if (StallCycles !== 16'd0 || FlushEvents !== 16'd0) begin
      nFail++; $display("FAIL reset_stats: got %h/%h want 0000/0000", StallCycles, FlushEvents);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back('{"post_reset", RUN});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    advance(0, 0, 0);
  endtask

  task automatic test_load_use();
    clearInputs();
    EXMemRead = 1; EXWriteRegAddr = 5'd5; IDRs = 5'd5; IDUsesRs = 1;
    expQ.push_back('{"loaduse_stall", STALL});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    advance(1, 0, 0);
    EXMemRead = 0;  // bubble now in EX
    expQ.push_back('{"loaduse_release", RUN});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    nTests++;
    if (StallCycles !== expStall) begin nFail++; $display("FAIL loaduse_stats: got %0d want %0d", StallCycles, expStall); end
    advance(0, 0, 0);
  endtask

  task automatic test_load_zero();
    // rows: load to $0 via rt; rt mismatch with rs match but rs unused
    for (int r = 0; r < 2; r++) begin
      clearInputs();
      EXMemRead = 1;
      if (r == 0) begin
        EXWriteRegAddr = 5'd0; IDRt = 5'd0; IDUsesRt = 1;
      end else begin
        EXWriteRegAddr = 5'd7; IDRs = 5'd7; IDUsesRs = 0; IDRt = 5'd8; IDUsesRt = 1;
      end
      expQ.push_back('{(r == 0) ? "load_zero" : "load_unused_rs", RUN});
      #2;
      e = expQ.pop_front(); nTests++;
      if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
      advance(0, 0, 0);
    end
    nTests++;
    if (StallCycles !== expStall) begin nFail++; $display("FAIL load_zero_stats: got %0d want %0d", StallCycles, expStall); end
  endtask

  task automatic test_mdu();
    for (int c = 0; c < 6; c++) begin
      clearInputs();
      if (c == 0) IDMduStart = 1; else IDReadsHiLo = 1;
      expQ.push_back('{$sformatf("mdu_c%0d", c), (c >= 1 && c <= 4) ? (STALL | BUSY) : RUN});
      #2;
      e = expQ.pop_front(); nTests++;
      if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
      advance(c >= 1 && c <= 4, 0, 0);
    end
    nTests++;
    if (StallCycles !== expStall) begin nFail++; $display("FAIL mdu_stats: got %0d want %0d", StallCycles, expStall); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] want;
    for (int c = 0; c < 11; c++) begin
      clearInputs();
      if (c <= 5) IDMduStart = 1;
      if (c >= 1 && c <= 4)      want = STALL | BUSY;
      else if (c >= 6 && c <= 9) want = RUN | BUSY;
      else                       want = RUN;
      expQ.push_back('{$sformatf("b2b_c%0d", c), want});
      #2;
      e = expQ.pop_front(); nTests++;
      if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
      advance(c >= 1 && c <= 4, 0, 0);
    end
    nTests++;
    if (StallCycles !== expStall) begin nFail++; $display("FAIL b2b_stats: got %0d want %0d", StallCycles, expStall); end
  endtask

  task automatic test_branch();
    clearInputs();
    BranchTakenEX = 1; IDMduStart = 1;
    EXMemRead = 1; EXWriteRegAddr = 5'd5; IDRs = 5'd5; IDUsesRs = 1;
    expQ.push_back('{"branch_over_hazard", SQUASH});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    advance(0, 1, 0);
    clearInputs();
    expQ.push_back('{"branch_no_mdu", RUN});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    nTests++;
    if (FlushEvents !== expFlush || StallCycles !== expStall) begin
      nFail++; $display("FAIL branch_stats: got %0d/%0d want %0d/%0d", FlushEvents, StallCycles, expFlush, expStall);
    end
    IDMduStart = 1;
    advance(0, 0, 0);
    clearInputs();
    BranchTakenEX = 1; IDReadsHiLo = 1;
    expQ.push_back('{"branch_while_busy", SQUASH | BUSY});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    advance(0, 1, 0);
    clearInputs();
    for (int c = 0; c < 5; c++) advance(0, 0, 0);
    nTests++;
    if (FlushEvents !== expFlush || StallCycles !== expStall || MduBusy !== 1'b0) begin
      nFail++; $display("FAIL branch_busy_stats: got %0d/%0d/%b want %0d/%0d/0", FlushEvents, StallCycles, MduBusy, expFlush, expStall);
    end
  endtask

  task automatic test_saturation();
    clearInputs();
    EXMemRead = 1; EXWriteRegAddr = 5'd9; IDRt = 5'd9; IDUsesRt = 1;
    expQ.push_back('{"sat_stall_rt", STALL});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    for (int i = 0; i < 32'h10000; i++) advance(1, 0, 0);
    nTests++;
    if (StallCycles !== 16'hFFFF || StallCycles !== expStall) begin
      nFail++; $display("FAIL sat_reach: got %h want %h", StallCycles, expStall);
    end
    advance(1, 0, 0);
    nTests++;
    if (StallCycles !== expStall) begin nFail++; $display("FAIL sat_hold: got %h want %h", StallCycles, expStall); end
    ClearStats = 1;
    advance(1, 0, 1);
    nTests++;
    if (StallCycles !== 16'd0 || FlushEvents !== 16'd0) begin
      nFail++; $display("FAIL clear_stats: got %h/%h want 0000/0000", StallCycles, FlushEvents);
    end
    ClearStats = 0;
    advance(1, 0, 0);
    nTests++;
    if (StallCycles !== expStall) begin nFail++; $display("FAIL after_clear: got %0d want %0d", StallCycles, expStall); end
    clearInputs();
    advance(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    clearInputs();
    IDMduStart = 1;
    advance(0, 0, 0);   // counter loaded with 4
    clearInputs();
    advance(0, 0, 0);   // counter now 3
    expQ.push_back('{"mid_busy", RUN | BUSY});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    rst_n = 1'b0;
    expStall = '0; expFlush = '0;
    expQ.push_back('{"mid_reset", RST});
    #1;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    nTests++;
    if (StallCycles !== expStall || FlushEvents !== expFlush) begin
      nFail++; $display("FAIL mid_reset_stats: got %h/%h want 0000/0000", StallCycles, FlushEvents);
    end
    #1;
    rst_n = 1'b1;
    expQ.push_back('{"mid_release", RUN});
    #1;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
    advance(0, 0, 0);
    expQ.push_back('{"mid_after_edge", RUN});
    #2;
    e = expQ.pop_front(); nTests++;
    if (ctl !== e.ctl) begin nFail++; $display("FAIL %s: got %b want %b", e.tag, ctl, e.ctl); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_zero();
    test_mdu();
    test_back_to_back();
    test_branch();
    test_saturation();
    test_reset_mid();
    if (expQ.size() != 0) begin
      nTests++; nFail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard and sequencing controller for the five-stage core. Watches the ID and EX stages and drives the PC write enable, the IF/ID write enable and flush, and the ID/EX flush. It resolves load-use stalls, multiply/divide busy stalls and taken-branch squashes, tracks the multi-cycle multiply/divide unit (MDU) with an internal countdown, and keeps saturating stall/flush statistics counters.

## Interface
- MDU_LATENCY, 8, cycles the MDU is busy after an accepted start; legal range 1..31.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IDRs  in  5  rs field of the instruction in ID.
- IDRt  in  5  rt field of the instruction in ID.
- IDUsesRs  in  1  ID instruction reads rs.
- IDUsesRt  in  1  ID instruction reads rt.
- IDMduStart  in  1  ID instruction is mult/multu/div/divu.
- IDReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- EXMemRead  in  1  MemRead output of the ID/EX register.
- EXWriteRegAddr  in  5  WriteRegAddr output of the ID/EX register.
- BranchTakenEX  in  1  branch/jump in EX resolved taken.
- ClearStats  in  1  synchronous clear of both statistics counters.
- PCWriteEnable  out  1  PC register load enable.
- IFIDWriteEnable  out  1  IF/ID WriteEnable.
- IFIDFlush  out  1  IF/ID Flush.
- IDEXFlush  out  1  ID/EX Flush (inserts a bubble).
- MduBusy  out  1  MDU countdown nonzero.
- StallCycles  out  16  count of stalled cycles, saturating.
- FlushEvents  out  16  count of taken-branch squashes, saturating.

## Operation
- LoadUse = EXMemRead & (EXWriteRegAddr != 0) & ((IDUsesRs & EXWriteRegAddr == IDRs) | (IDUsesRt & EXWriteRegAddr == IDRt)).
- MduHazard = MduBusy & (IDMduStart | IDReadsHiLo).
- Stall = (LoadUse | MduHazard) & ~BranchTakenEX.
- Priority: reset > BranchTakenEX > Stall > normal.
- Reset asserted: PCWriteEnable=0, IFIDWriteEnable=0, IFIDFlush=1, IDEXFlush=1; MDU counter, StallCycles and FlushEvents all cleared.
- BranchTakenEX: PCWriteEnable=1, IFIDWriteEnable=1, IFIDFlush=1, IDEXFlush=1. The ID instruction is wrong-path, so an IDMduStart in the same cycle is squashed and does not load the counter.
- Stall: PCWriteEnable=0, IFIDWriteEnable=0, IFIDFlush=0, IDEXFlush=1. PC and IF/ID hold their values and a bubble enters EX.
- Normal: PCWriteEnable=1, IFIDWriteEnable=1, IFIDFlush=0, IDEXFlush=0.
- MDU counter (5 bits):
  - Loads MDU_LATENCY on an edge where IDMduStart=1, BranchTakenEX=0 and Stall=0.
  - Otherwise decrements when nonzero and holds at 0.
  - MduBusy = (counter != 0).
- StallCycles: +1 on every edge with Stall=1; saturates at 0xFFFF.
- FlushEvents: +1 on every edge with BranchTakenEX=1; saturates at 0xFFFF.
- ClearStats zeroes both statistics counters on the edge and overrides any increment in the same cycle. It does not affect the MDU counter.

## Timing
- Control outputs are combinational from the inputs and MduBusy, with no added latency. The pipeline registers act on them at the same edge.
- MDU start accepted at edge N: MduBusy=1 from N through edge N+MDU_LATENCY, then 0.
- A dependent MDU/HI-LO instruction in ID stalls while MduBusy=1 and proceeds in the first cycle MduBusy=0.
- Load-use stall lasts exactly one cycle. After the bubble, EXMemRead=0 in EX, so LoadUse drops.
- Reset deasserted asynchronously mid-countdown: the counter is already 0, and the first cycle after release is normal.
- Statistics outputs update one edge after the qualifying cycle.

## Test plan
- Load-use: EXMemRead=1, EXWriteRegAddr=5, IDRs=5, IDUsesRs=1 -> PCWriteEnable=0, IFIDWriteEnable=0, IDEXFlush=1 for one cycle; StallCycles goes 0->1.
- Load to $0: EXMemRead=1, EXWriteRegAddr=0, IDRt=0, IDUsesRt=1 -> no stall; all enables 1, both flushes 0.
- MDU: MDU_LATENCY=4, IDMduStart pulsed at cycle 0, then IDReadsHiLo=1 from cycle 1 -> MduBusy high 4 cycles, stall in cycles 1-4, proceed in cycle 5; StallCycles=4.
- Branch over hazard: BranchTakenEX=1 with LoadUse=1 and IDMduStart=1 -> IFIDFlush=1, IDEXFlush=1, PCWriteEnable=1; MduBusy stays 0; FlushEvents +1, StallCycles unchanged.
- Saturation/clear: force 0x10000 stall cycles -> StallCycles=0xFFFF and holds; ClearStats with Stall=1 -> 0 on the next edge.
- Reset mid-countdown: rst_n low at MDU count 3 -> MduBusy=0 immediately, outputs at reset values, counters 0; after release, normal outputs.
